equation_generator: RTL and testbench

Producer side of the alarm's equation interface. On each request from the top-level control FSM it builds one arithmetic problem: two 4-bit operands, an operator and the expected 8-bit answer. Operands come from an internal LFSR mixed with the free-running seconds counter. The problem is held on a valid/ack handshake until the answer checker acknowledges a correct entry; the operands and operator also drive the display.

---
 rtl/equation_generator_if.sv | 24 ++
 rtl/equation_generator.sv | 130 +++++++++++++
 tb/tb_equation_generator.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/equation_generator_if.sv
// Equation handshake bundle between the equation producer and its consumers.
// The slave modport is the producer's view; the master modport is the controller/checker view.
interface equation_generator_if;
    logic       i_start;
    logic [6:0] i_seed;
    logic [1:0] i_level;
    logic       i_ack;
    logic [3:0] o_operand_a;
    logic [3:0] o_operand_b;
    logic [1:0] o_operator;
    logic [7:0] o_expected;
    logic       o_valid;
    logic       o_busy;

    modport slave (
        input  i_start, i_seed, i_level, i_ack,
        output o_operand_a, o_operand_b, o_operator, o_expected, o_valid, o_busy
    );

    modport master (
        output i_start, i_seed, i_level, i_ack,
        input  o_operand_a, o_operand_b, o_operator, o_expected, o_valid, o_busy
    );
endinterface

// File: rtl/equation_generator.sv
// Builds one arithmetic problem per request from an LFSR mixed with a seed and holds it
// on a valid/ack handshake. Multiplication is an iterative 4-step shift-add.
module equation_generator #(
    parameter logic [7:0] LFSR_INIT = 8'hA5
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    equation_generator_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_PICK_OPS, S_PICK_OP, S_COMPUTE, S_ACCUM, S_PRESENT
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10
    } op_t;

    state_t     r_state, w_next_state;
    op_t        r_operator, w_op;
    logic [7:0] r_lfsr, w_step, w_lfsr_cand, w_lfsr_next;
    logic [3:0] r_op_a, r_op_b;
    logic [7:0] r_expected, r_acc;
    logic [1:0] r_cnt;
    logic       r_valid, r_busy;
    logic       w_swap;
    logic [7:0] w_addend, w_acc_sum, w_arith;

    // Fibonacci step; the seed is folded in only on the edge that accepts Start.
    assign w_step      = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_lfsr_cand = (r_state == S_IDLE && bus.i_start) ? (w_step ^ {1'b0, bus.i_seed}) : w_step;
    assign w_lfsr_next = (w_lfsr_cand == 8'h00) ? LFSR_INIT : w_lfsr_cand;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_op = OP_ADD;
        unique case (bus.i_level)
            2'd0:    w_op = OP_ADD;
            2'd1:    w_op = r_lfsr[0] ? OP_SUB : OP_ADD;
            default: begin
                unique case (r_lfsr[1:0])
                    2'd1:    w_op = OP_SUB;
                    2'd2:    w_op = OP_MUL;
                    default: w_op = OP_ADD;
                endcase
            end
        endcase
    end

    assign w_swap    = (w_op == OP_SUB) && (r_op_a < r_op_b);
    assign w_addend  = r_op_b[r_cnt] ? ({4'b0000, r_op_a} << r_cnt) : 8'd0;
    assign w_acc_sum = r_acc + w_addend;
    assign w_arith   = (r_operator == OP_SUB) ? ({4'b0000, r_op_a} - {4'b0000, r_op_b})
                                              : ({4'b0000, r_op_a} + {4'b0000, r_op_b});

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:     if (bus.i_start) w_next_state = S_PICK_OPS;
            S_PICK_OPS: w_next_state = S_PICK_OP;
            S_PICK_OP:  w_next_state = S_COMPUTE;
            S_COMPUTE:  w_next_state = S_ACCUM;
            S_ACCUM:    if (r_operator != OP_MUL || r_cnt == 2'd3) w_next_state = S_PRESENT;
            S_PRESENT:  if (bus.i_ack) w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // COMPUTE spends its entry cycle clearing the accumulator; the arithmetic runs in ACCUM.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr     <= LFSR_INIT;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_operator <= OP_ADD;
            r_expected <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_lfsr  <= w_lfsr_next;
            r_valid <= (w_next_state == S_PRESENT);
            r_busy  <= (w_next_state != S_IDLE);
            unique case (r_state)
                S_PICK_OPS: begin
                    r_op_a <= r_lfsr[3:0];
                    r_op_b <= r_lfsr[7:4];
                end
                S_PICK_OP: begin
                    r_operator <= w_op;
                    if (w_swap) begin
                        r_op_a <= r_op_b;
                        r_op_b <= r_op_a;
                    end
                end
                S_COMPUTE: begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end
                S_ACCUM: begin
                    if (r_operator == OP_MUL) begin
                        r_acc <= w_acc_sum;
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) r_expected <= w_acc_sum;
                    end else begin
                        r_expected <= w_arith;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_operand_a = r_op_a;
    assign bus.o_operand_b = r_op_b;
    assign bus.o_operator  = r_operator;
    assign bus.o_expected  = r_expected;
    assign bus.o_valid     = r_valid;
    assign bus.o_busy      = r_busy;

endmodule

// File: tb/tb_equation_generator.sv
// Directed bench for equation_generator: hand-computed LFSR/operand/answer vectors,
// handshake timing, ignore rules and asynchronous reset behaviour.
module tb_equation_generator;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    equation_generator_if bus();

    equation_generator dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "/a"},     bus.o_operand_a, 0);
        check({tag, "/b"},     bus.o_operand_b, 0);
        check({tag, "/op"},    bus.o_operator,  0);
        check({tag, "/exp"},   bus.o_expected,  0);
        check({tag, "/valid"}, bus.o_valid,     0);
        check({tag, "/busy"},  bus.o_busy,      0);
    endtask

    task automatic apply_reset();
        rst_n       = 1'b0;
        bus.i_start = 1'b0;
        bus.i_ack   = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // Issues Start on edge 0, then follows the problem edge by edge until Valid should rise.
    task automatic run_eq(input string tag, input logic [6:0] seed, input logic [1:0] level,
                          input int lat, input logic [3:0] ea, input logic [3:0] eb,
                          input logic [1:0] eop, input logic [7:0] eexp, input bit pulse_start);
        bus.i_seed  = seed;
        bus.i_level = level;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        check({tag, "/busy_e0"}, bus.o_busy, 1);
        for (int e = 1; e <= lat; e++) begin
            bus.i_start = pulse_start && (e == 3 || e == 4);
            tick();
            check($sformatf("%s/valid_e%0d", tag, e), bus.o_valid, (e == lat));
            check($sformatf("%s/busy_e%0d", tag, e), bus.o_busy, 1);
        end
        bus.i_start = 1'b0;
        check({tag, "/a"},   bus.o_operand_a, ea);
        check({tag, "/b"},   bus.o_operand_b, eb);
        check({tag, "/op"},  bus.o_operator,  eop);
        check({tag, "/exp"}, bus.o_expected,  eexp);
    endtask

    task automatic do_ack(input string tag);
        bus.i_ack = 1'b1;
        tick();
        bus.i_ack = 1'b0;
        check({tag, "/ack_valid"}, bus.o_valid, 0);
        check({tag, "/ack_busy"},  bus.o_busy,  0);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.i_start = 1'b1;
        bus.i_ack   = 1'b0;
        bus.i_seed  = 7'd0;
        bus.i_level = 2'd0;

        // Reset held with Start high: nothing moves.
        repeat (5) begin
            tick();
            check("rst/valid", bus.o_valid, 0);
            check("rst/busy",  bus.o_busy,  0);
        end
        check_all_zero("rst");
        rst_n = 1'b1;

        // Add: lfsr 4A -> A=10 B=4, 14.
        run_eq("add", 7'h00, 2'd0, 4, 4'd10, 4'd4, 2'b00, 8'd14, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("add/hold_valid", bus.o_valid, 1);
        end
        check("add/hold_exp", bus.o_expected, 14);
        check("add/hold_a",   bus.o_operand_a, 10);
        do_ack("add");
        bus.i_ack = 1'b1;
        repeat (3) begin
            tick();
            check("idle_ack/busy",  bus.o_busy,  0);
            check("idle_ack/valid", bus.o_valid, 0);
        end
        bus.i_ack = 1'b0;

        // Sub with no swap.
        apply_reset();
        run_eq("sub0", 7'h00, 2'd1, 4, 4'd10, 4'd4, 2'b01, 8'd6, 1'b0);
        do_ack("sub0");

        // Sub with swap, then Start+Ack together and Start held.
        apply_reset();
        run_eq("sub28", 7'h28, 2'd1, 4, 4'd6, 4'd2, 2'b01, 8'd4, 1'b0);
        bus.i_start = 1'b1;
        bus.i_ack   = 1'b1;
        tick();
        bus.i_ack = 1'b0;
        check("both/valid", bus.o_valid, 0);
        check("both/busy",  bus.o_busy,  0);
        tick();
        check("held/busy", bus.o_busy, 1);
        bus.i_start = 1'b0;

        // Mul with Start pulses in COMPUTE that must be ignored and not queued.
        apply_reset();
        run_eq("mul", 7'h17, 2'd2, 7, 4'd13, 4'd5, 2'b10, 8'd65, 1'b1);
        do_ack("mul");
        repeat (2) begin
            tick();
            check("mul/no_queue_busy", bus.o_busy, 0);
        end

        // Zero guard: mix yields 0, lfsr falls back to A5.
        apply_reset();
        run_eq("zero", 7'h4A, 2'd0, 4, 4'd5, 4'd10, 2'b00, 8'd15, 1'b0);
        do_ack("zero");

        // Reset during multiply iteration 2, then a clean rerun.
        apply_reset();
        bus.i_seed  = 7'h17;
        bus.i_level = 2'd2;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        repeat (5) tick();
        check("midrst/busy_before", bus.o_busy, 1);
        check("midrst/a_before",    bus.o_operand_a, 13);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        run_eq("rerun", 7'h17, 2'd2, 7, 4'd13, 4'd5, 2'b10, 8'd65, 1'b0);
        do_ack("rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
